// File: rtl/ceyloniac_mem_pkg.sv
// Shared definitions for the RAM responder: FSM encoding and default timing.
package ceyloniac_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/ceyloniac_ram_array.sv
// Word-addressed storage: one synchronous write port, one synchronous read port
// whose output register can be forced to zero for out-of-range reads.
module ceyloniac_ram_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; holds the last result until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/ceyloniac_ram_responder.sv
// Memory-side responder: latches a level request, inserts wait states,
// performs the access, then acknowledges with a one-cycle ram_enable.
module ceyloniac_ram_responder
    import ceyloniac_mem_pkg::*;
#(
    parameter int unsigned RAM_DATA_WIDTH = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned WAIT_STATES    = DEFAULT_WAIT_STATES,
    parameter int unsigned WAIT_CNT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ram_write_data,
    input  logic                      ram_read_enable,
    input  logic                      ram_write_enable,
    output logic [RAM_DATA_WIDTH-1:0] ram_read_data,
    output logic                      ram_enable,
    output logic                      busy,
    input  logic                      load_enable,
    input  logic [RAM_ADDR_WIDTH-1:0] load_addr,
    input  logic [RAM_DATA_WIDTH-1:0] load_data,
    output logic                      addr_error,
    output logic                      protocol_error
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [RAM_ADDR_WIDTH:0] DEPTH_LIM = (RAM_ADDR_WIDTH+1)'(MEM_DEPTH);

    // Range check on the full request address before truncation to an index.
    function automatic logic in_range(input logic [RAM_ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    state_t                      state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [RAM_ADDR_WIDTH-1:0]   addr_q;
    logic [RAM_DATA_WIDTH-1:0]   data_q;
    logic                        wr_q;
    logic                        latch;
    logic                        set_addr_err;
    logic                        set_proto;
    logic                        mem_we;
    logic [IDX_W-1:0]            mem_waddr;
    logic [RAM_DATA_WIDTH-1:0]   mem_wdata;
    logic                        mem_re;
    logic                        mem_rzero;
    logic [IDX_W-1:0]            mem_raddr;

    // Next-state, request latch control and memory port steering.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch        = 1'b0;
        set_addr_err = 1'b0;
        set_proto    = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = load_addr[IDX_W-1:0];
        mem_wdata    = load_data;
        mem_re       = 1'b0;
        mem_rzero    = 1'b0;
        mem_raddr    = addr_q[IDX_W-1:0];
        case (state_q)
            IDLE: begin
                if (load_enable) begin
                    // Loads take priority; a concurrent request stays pending.
                    mem_we = in_range(load_addr);
                end else if (ram_read_enable || ram_write_enable) begin
                    latch     = 1'b1;
                    cnt_d     = WAIT_CNT_WIDTH'(WAIT_STATES);
                    state_d   = WAIT;
                    set_proto = ram_read_enable && ram_write_enable;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CNT_WIDTH'(1);
                end else begin
                    state_d      = ACK;
                    set_addr_err = !in_range(addr_q);
                    if (wr_q) begin
                        mem_we    = in_range(addr_q);
                        mem_waddr = addr_q[IDX_W-1:0];
                        mem_wdata = data_q;
                    end else begin
                        mem_re    = 1'b1;
                        mem_rzero = !in_range(addr_q);
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, registered status outputs and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ram_enable     <= 1'b0;
            busy           <= 1'b0;
            addr_error     <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ram_enable     <= (state_d == ACK);
            busy           <= (state_d != IDLE);
            addr_error     <= addr_error | set_addr_err;
            protocol_error <= protocol_error | set_proto;
        end
    end

    // Request capture; write wins when both enables are high.
    always_ff @(posedge clk) begin
        if (latch) begin
            addr_q <= ram_addr;
            data_q <= ram_write_data;
            wr_q   <= ram_write_enable;
        end
    end

    ceyloniac_ram_array #(
        .DATA_W (RAM_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we && !reset),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .rzero (mem_rzero),
        .raddr (mem_raddr),
        .rdata (ram_read_data)
    );

endmodule

// File: tb/tb_ceyloniac_ram_responder.sv
// Directed bench for the RAM responder: main instance with two wait states,
// second instance with zero wait states for the back-to-back pulse pattern.
module tb_ceyloniac_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_read_enable, ram_write_enable;
    logic [31:0] ram_read_data;
    logic        ram_enable, busy;
    logic        load_enable;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        addr_error, protocol_error;

    logic [15:0] z_addr;
    logic [31:0] z_wdata;
    logic        z_re, z_we;
    logic [31:0] z_rdata;
    logic        z_enable, z_busy;
    logic        z_load_en;
    logic [15:0] z_load_addr;
    logic [31:0] z_load_data;
    logic        z_addr_err, z_proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ceyloniac_ram_responder #(.WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .ram_read_data(ram_read_data), .ram_enable(ram_enable), .busy(busy),
        .load_enable(load_enable), .load_addr(load_addr), .load_data(load_data),
        .addr_error(addr_error), .protocol_error(protocol_error)
    );

    ceyloniac_ram_responder #(.WAIT_STATES(0)) dut_zero (
        .clk(clk), .reset(reset),
        .ram_addr(z_addr), .ram_write_data(z_wdata),
        .ram_read_enable(z_re), .ram_write_enable(z_we),
        .ram_read_data(z_rdata), .ram_enable(z_enable), .busy(z_busy),
        .load_enable(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data),
        .addr_error(z_addr_err), .protocol_error(z_proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Preload one word through the bring-up port (called at a negedge).
    task automatic load(input logic [15:0] a, input logic [31:0] d);
        load_enable = 1'b1;
        load_addr   = a;
        load_data   = d;
        @(negedge clk);
        load_enable = 1'b0;
    endtask

    // One access with two wait states: ack expected 4 samples after driving.
    task automatic access(input string tag, input logic [15:0] a, input logic [31:0] d,
                          input logic rd, input logic wr);
        int lat;
        ram_addr         = a;
        ram_write_data   = d;
        ram_read_enable  = rd;
        ram_write_enable = wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end while (!ram_enable && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_one_cycle"}, 32'(ram_enable), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ram_addr = '0; ram_write_data = '0; ram_read_enable = 1'b0; ram_write_enable = 1'b0;
        load_enable = 1'b0; load_addr = '0; load_data = '0;
        z_addr = '0; z_wdata = '0; z_re = 1'b0; z_we = 1'b0;
        z_load_en = 1'b0; z_load_addr = '0; z_load_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_enable", 32'(ram_enable), 32'd0);
        chk("rst_rdata", ram_read_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr_err", 32'(addr_error), 32'd0);
        chk("rst_proto_err", 32'(protocol_error), 32'd0);

        // Bring-up loads, including an out-of-range one that must be ignored.
        load(16'd5, 32'hDEADBEEF);
        load(16'd7, 32'h00000001);
        load(16'd0, 32'h11110000);
        load(16'd976, 32'h0BAD0976);
        load(16'd1024, 32'hEEEEEEEE);
        chk("load_no_error", 32'(addr_error), 32'd0);

        // Preload then read.
        access("rd5", 16'd5, 32'h0, 1'b1, 1'b0);
        chk("rd5_data", ram_read_data, 32'hDEADBEEF);

        // Write then read; read data holds across the write.
        access("wr10", 16'd10, 32'h12345678, 1'b0, 1'b1);
        chk("wr10_rdata_held", ram_read_data, 32'hDEADBEEF);
        access("rd10", 16'd10, 32'h0, 1'b1, 1'b0);
        chk("rd10_data", ram_read_data, 32'h12345678);

        // Simultaneous read and write: write wins, protocol error is sticky.
        access("rw3", 16'd3, 32'hA5A5A5A5, 1'b1, 1'b1);
        chk("rw3_proto_err", 32'(protocol_error), 32'd1);
        chk("rw3_rdata_held", ram_read_data, 32'h12345678);
        access("rd3", 16'd3, 32'h0, 1'b1, 1'b0);
        chk("rd3_data", ram_read_data, 32'hA5A5A5A5);
        chk("rd3_proto_sticky", 32'(protocol_error), 32'd1);

        // Out-of-range read and write.
        access("rd1024", 16'd1024, 32'h0, 1'b1, 1'b0);
        chk("rd1024_data", ram_read_data, 32'd0);
        chk("rd1024_addr_err", 32'(addr_error), 32'd1);
        access("wr2000", 16'd2000, 32'hCAFECAFE, 1'b0, 1'b1);
        access("rd976", 16'd976, 32'h0, 1'b1, 1'b0);
        chk("rd976_no_alias", ram_read_data, 32'h0BAD0976);
        access("rd0", 16'd0, 32'h0, 1'b1, 1'b0);
        chk("rd0_no_load_alias", ram_read_data, 32'h11110000);
        chk("addr_err_sticky", 32'(addr_error), 32'd1);

        // Reset while a write to addr 7 is waiting.
        ram_addr = 16'd7; ram_write_data = 32'h00000099; ram_write_enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        ram_write_enable = 1'b0;
        @(negedge clk);
        chk("rst_mid_enable", 32'(ram_enable), 32'd0);
        chk("rst_mid_rdata", ram_read_data, 32'd0);
        chk("rst_mid_busy_clr", 32'(busy), 32'd0);
        chk("rst_mid_addr_err", 32'(addr_error), 32'd0);
        chk("rst_mid_proto_err", 32'(protocol_error), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_ack", 32'(ram_enable), 32'd0);
        end
        access("rd7", 16'd7, 32'h0, 1'b1, 1'b0);
        chk("rd7_write_dropped", ram_read_data, 32'h00000001);

        // Zero wait states with the read held: ack every third cycle.
        z_re = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("zero_ws_pulse%0d", i), 32'(z_enable), (i % 3 == 2) ? 32'd1 : 32'd0);
        end
        z_re = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
